// File: rtl/ahb_slave_mem_if.sv
// ahb_slave_mem_if: AHB-Lite signal bundle between a master and ahb_slave_mem
//   master drives hsel/haddr/hwrite/htrans/hburst/hwdata/hready
//   slave drives hreadyout/hresp/hrdata
interface ahb_slave_mem_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
);
   logic              hsel;
   logic [ADDR_W-1:0] haddr;
   logic              hwrite;
   logic [1:0]        htrans;
   logic [2:0]        hburst;
   logic [DATA_W-1:0] hwdata;
   logic              hready;
   logic              hreadyout;
   logic              hresp;
   logic [DATA_W-1:0] hrdata;
   modport master (
      output hsel, haddr, hwrite, htrans, hburst, hwdata, hready,
      input  hreadyout, hresp, hrdata
   );
   modport slave (
      input  hsel, haddr, hwrite, htrans, hburst, hwdata, hready,
      output hreadyout, hresp, hrdata
   );
endinterface

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB-Lite memory responder with optional wait states (AHB_SLV_WAIT_EN) and two-cycle ERROR for addr >= DEPTH
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : ahb_slave_mem_if.slave (select/address/control/wdata in; hreadyout/hresp/hrdata out)
module ahb_slave_mem #(
   parameter int ADDR_W      = 10,
   parameter int DATA_W      = 8,
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input logic           clk,
   input logic           rst,
   ahb_slave_mem_if.slave bus
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;
   state_t            state;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] addr_q;
   logic              wr_q, ready_st, acc, oor, wr_done, fwd, unused;
`ifdef AHB_SLV_WAIT_EN
   localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES + 1) : 1;
   logic [CW-1:0] cnt;
`else
   localparam int unused_wait = WAIT_CYCLES;
`endif
   assign unused   = ^bus.hburst;
   // only states that present hreadyout=1 can take a new address phase
   assign ready_st = state == IDLE || state == DATA || state == ERR2;
   assign acc      = ready_st & bus.hsel & bus.hready & bus.htrans[1];
   // wide compare so DEPTH == 2**ADDR_W never flags an error
   assign oor      = 32'(bus.haddr) >= 32'(DEPTH);
   assign wr_done  = state == DATA && wr_q;
   // a read accepted on the edge that completes a write to the same word sees the new data
   assign fwd      = wr_done && addr_q == bus.haddr;
   always_ff @(posedge clk)
      if (wr_done && !rst) mem[addr_q[AW-1:0]] <= bus.hwdata;
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         bus.hreadyout <= 1'b1;
         bus.hresp     <= 1'b0;
         bus.hrdata    <= '0;
         addr_q        <= '0;
         wr_q          <= 1'b0;
`ifdef AHB_SLV_WAIT_EN
         cnt           <= '0;
`endif
      end else begin
         if (acc) begin
            addr_q <= bus.haddr;
            wr_q   <= bus.hwrite & ~oor;
         end else if (ready_st) wr_q <= 1'b0;
         if (acc && !bus.hwrite && !oor) bus.hrdata <= fwd ? bus.hwdata : mem[bus.haddr[AW-1:0]];
         case (state)
`ifdef AHB_SLV_WAIT_EN
            WAIT: begin
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  state         <= DATA;
                  bus.hreadyout <= 1'b1;
               end
            end
`endif
            ERR1: begin
               state         <= ERR2;
               bus.hreadyout <= 1'b1;
            end
            default: begin
               if (!acc) begin
                  state         <= IDLE;
                  bus.hreadyout <= 1'b1;
                  bus.hresp     <= 1'b0;
               end else if (oor) begin
                  state         <= ERR1;
                  bus.hreadyout <= 1'b0;
                  bus.hresp     <= 1'b1;
               end
`ifdef AHB_SLV_WAIT_EN
               else if (WAIT_CYCLES > 0) begin
                  state         <= WAIT;
                  bus.hreadyout <= 1'b0;
                  bus.hresp     <= 1'b0;
                  cnt           <= CW'(WAIT_CYCLES);
               end
`endif
               else begin
                  state         <= DATA;
                  bus.hreadyout <= 1'b1;
                  bus.hresp     <= 1'b0;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb_ahb_slave_mem: table, directed and random checks of ahb_slave_mem against a transaction-level model
module tb_ahb_slave_mem;
   localparam int DEPTH = 512;
   localparam int WC    = 2;
`ifdef AHB_SLV_WAIT_EN
   localparam int WAITS = WC;
`else
   localparam int WAITS = 0;
`endif
   typedef struct {bit wr; bit [9:0] a; bit [7:0] d; bit sel; bit [1:0] tr;} xf_t;
   typedef struct {xf_t x; bit err; bit rck; bit [7:0] rd;} vec_t;
   logic clk, rst, hold;
   ahb_slave_mem_if #(.ADDR_W(10), .DATA_W(8)) bus();
   ahb_slave_mem #(.ADDR_W(10), .DATA_W(8), .DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
   assign bus.hready = bus.hreadyout & ~hold;
   initial clk = 1'b0;
   always #5 clk = ~clk;
   int       total, bad;
   bit [7:0] model [1024];
   xf_t      q[$];
   bit [7:0] last_rd;
   bit       last_err;
   vec_t     tv [17];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask
   // drives the queued transfers back to back and checks each response against the model
   task automatic run_q();
      xf_t      cur;
      bit       dv = 0, fresh = 0, act = 0, er = 0;
      int       lows = 0, exp_lows = 0, budget;
      bit [7:0] exp_d = 0;
      budget = q.size() * (WAITS + 4) + 20;
      while ((q.size() > 0 || dv) && budget > 0) begin
         @(negedge clk);
         budget--;
         if (dv && fresh) begin
            bus.hwdata = cur.d;
            fresh = 0;
         end
         if (dv) begin
            if (!bus.hreadyout) begin
               lows++;
               chk("wait_resp", bus.hresp, er);
               continue;
            end
            chk("low_cycles", lows, exp_lows);
            chk("resp", bus.hresp, er);
            if (act && !cur.wr && !er) chk("rdata", bus.hrdata, exp_d);
            last_err = bus.hresp;
            last_rd  = bus.hrdata;
            dv = 0;
         end
         if (q.size() > 0) begin
            cur = q.pop_front();
            bus.hsel   = cur.sel;
            bus.haddr  = cur.a;
            bus.hwrite = cur.wr;
            bus.htrans = cur.tr;
            bus.hburst = 3'($urandom);
            act = cur.sel && cur.tr[1];
            er  = act && cur.a >= DEPTH;
            exp_lows = er ? 1 : act ? WAITS : 0;
            if (act && !er) begin
               if (cur.wr) model[cur.a] = cur.d;
               else exp_d = model[cur.a];
            end
            lows = 0;
            dv = 1;
            fresh = 1;
         end else begin
            bus.hsel = 1'b0;
            bus.htrans = 2'b00;
         end
      end
      chk("drain", q.size() + int'(dv), 0);
      bus.hsel = 1'b0;
      bus.htrans = 2'b00;
   endtask
   initial begin
      total = 0;
      bad = 0;
      hold = 1'b0;
      rst = 1'b1;
      bus.hsel = 1'b0; bus.haddr = '0; bus.hwrite = 1'b0; bus.htrans = 2'b00;
      bus.hburst = '0; bus.hwdata = '0;
      tv[0]  = '{'{1, 10'd1,   8'h01, 1, 2'b10}, 0, 0, 8'h00};
      tv[1]  = '{'{0, 10'd1,   8'h00, 1, 2'b10}, 0, 1, 8'h01};
      tv[2]  = '{'{1, 10'd7,   8'h5A, 1, 2'b10}, 0, 0, 8'h00};
      tv[3]  = '{'{0, 10'd7,   8'h00, 1, 2'b10}, 0, 1, 8'h5A};
      tv[4]  = '{'{1, 10'd600, 8'hFF, 1, 2'b10}, 1, 0, 8'h00};
      tv[5]  = '{'{0, 10'd600, 8'h00, 1, 2'b10}, 1, 0, 8'h00};
      tv[6]  = '{'{1, 10'd2,   8'h33, 1, 2'b00}, 0, 0, 8'h00};
      tv[7]  = '{'{1, 10'd2,   8'h44, 0, 2'b10}, 0, 0, 8'h00};
      tv[8]  = '{'{0, 10'd2,   8'h00, 1, 2'b10}, 0, 1, 8'h00};
      tv[9]  = '{'{1, 10'd511, 8'hA5, 1, 2'b11}, 0, 0, 8'h00};
      tv[10] = '{'{0, 10'd511, 8'h00, 1, 2'b11}, 0, 1, 8'hA5};
      tv[11] = '{'{0, 10'd512, 8'h00, 1, 2'b10}, 1, 0, 8'h00};
      tv[12] = '{'{1, 10'd1,   8'h77, 1, 2'b01}, 0, 0, 8'h00};
      tv[13] = '{'{0, 10'd1,   8'h00, 1, 2'b10}, 0, 1, 8'h01};
      tv[14] = '{'{1, 10'd4,   8'h21, 1, 2'b10}, 0, 0, 8'h00};
      tv[15] = '{'{0, 10'd4,   8'h00, 1, 2'b11}, 0, 1, 8'h21};
      tv[16] = '{'{0, 10'd88,  8'h00, 1, 2'b10}, 0, 1, 8'h00};
      repeat (2) @(negedge clk);
      chk("rst_hreadyout", bus.hreadyout, 1);
      chk("rst_hresp", bus.hresp, 0);
      chk("rst_hrdata", bus.hrdata, 0);
      rst = 1'b0;
      for (int i = 0; i < 17; i++) begin
         q.push_back(tv[i].x);
         run_q();
         chk($sformatf("tbl%0d_resp", i), last_err, tv[i].err);
         if (tv[i].rck) chk($sformatf("tbl%0d_rdata", i), last_rd, tv[i].rd);
      end
      // back-to-back write then read of the same word needs forwarding
      q.push_back('{1, 10'd7, 8'hC3, 1, 2'b10});
      q.push_back('{0, 10'd7, 8'h00, 1, 2'b10});
      run_q();
      chk("fwd_rdata", last_rd, 8'hC3);
      // an error leaves hrdata at the last good read
      q.push_back('{0, 10'd511, 8'h00, 1, 2'b10});
      run_q();
      q.push_back('{0, 10'd600, 8'h00, 1, 2'b10});
      run_q();
      chk("err_hold_rdata", last_rd, 8'hA5);
      // address phase with hready low must be ignored
      @(negedge clk);
      hold = 1'b1;
      bus.hsel = 1'b1; bus.haddr = 10'd5; bus.hwrite = 1'b1; bus.htrans = 2'b10;
      @(negedge clk);
      bus.hwdata = 8'h99;
      hold = 1'b0;
      bus.hsel = 1'b0; bus.htrans = 2'b00;
      chk("hold_hreadyout", bus.hreadyout, 1);
      chk("hold_hresp", bus.hresp, 0);
      @(negedge clk);
      q.push_back('{0, 10'd5, 8'h00, 1, 2'b10});
      run_q();
      chk("hold_mem", last_rd, 8'h00);
      // reset while a write to addr 4 is in flight
      @(negedge clk);
      bus.hsel = 1'b1; bus.haddr = 10'd4; bus.hwrite = 1'b1; bus.htrans = 2'b10;
      @(negedge clk);
      bus.hwdata = 8'h66;
      bus.hsel = 1'b0; bus.htrans = 2'b00;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_hreadyout", bus.hreadyout, 1);
      chk("midrst_hresp", bus.hresp, 0);
      chk("midrst_hrdata", bus.hrdata, 0);
      q.push_back('{0, 10'd4, 8'h00, 1, 2'b10});
      run_q();
      chk("midrst_mem", last_rd, 8'h21);
      for (int i = 0; i < 300; i++) begin
         xf_t x;
         int  r;
         r = $urandom_range(0, 99);
         x.a   = r < 70 ? 10'($urandom_range(0, 15)) : r < 85 ? 10'($urandom_range(500, 511)) : 10'($urandom_range(512, 1023));
         x.wr  = 1'($urandom);
         x.d   = 8'($urandom);
         x.sel = $urandom_range(0, 9) != 0;
         x.tr  = 2'($urandom);
         q.push_back(x);
      end
      run_q();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
